io_peripheral: RTL and testbench

- Memory-mapped I/O responder on the core's data-memory bus; the target end of the loads and stores the MEM stage issues.
- Decodes one 256-byte page and returns read data with the same one-cycle registered latency as the data RAM.
- Drives the 11-bit output bus and samples the 11-bit input bus through a synchroniser and a debouncer.
- Latches rising edges on inputs and provides a free-running timer with a compare flag.

---
 rtl/io_peripheral.sv | 146 ++++++++++++++
 tb/tb_io_peripheral.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/io_peripheral.sv
// Memory-mapped I/O responder: output port, debounced inputs, edge flags, timer/compare.
// Latency: q is registered, one cycle after the address; hit is combinational.
// Backpressure: none; every bus cycle is accepted, writes apply at the edge with wren && hit.
module io_peripheral #(
    parameter logic [31:0] IO_BASE      = 32'h0000_0400,
    parameter int          IO_WIDTH     = 11,
    parameter int          DEBOUNCE_LEN = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         address,
    input  logic [31:0]         data,
    input  logic                wren,
    output logic                hit,
    output logic [31:0]         q,
    input  logic [IO_WIDTH-1:0] io_input_bus,
    output logic [IO_WIDTH-1:0] io_output_bus
);

    localparam logic [5:0] REG_OUT    = 6'h00;
    localparam logic [5:0] REG_IN     = 6'h01;
    localparam logic [5:0] REG_EDGE   = 6'h02;
    localparam logic [5:0] REG_TIMER  = 6'h03;
    localparam logic [5:0] REG_TCMP   = 6'h04;
    localparam logic [5:0] REG_STATUS = 6'h05;

    // Count at which a persistent difference is accepted into the debounced value.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_LEN - 1);

    logic [IO_WIDTH-1:0]        sync1_q, sync1_d;
    logic [IO_WIDTH-1:0]        sync2_q, sync2_d;
    logic [IO_WIDTH-1:0]        deb_q, deb_d;
    logic [IO_WIDTH-1:0][7:0]   cnt_q, cnt_d;
    logic [IO_WIDTH-1:0]        out_q, out_d;
    logic [IO_WIDTH-1:0]        edge_flags_q, edge_flags_d;
    logic [31:0]                timer_q, timer_d;
    logic [31:0]                tcmp_q, tcmp_d;
    logic                       status_q, status_d;
    logic [31:0]                rdata_q, rdata_d;

    logic                       wr;
    logic [5:0]                 sel;
    logic [31:0]                rdata;
    logic                       unused_addr_lsb;

    assign sel             = address[7:2];
    assign hit             = (address[31:8] == IO_BASE[31:8]);
    assign wr              = wren && hit;
    assign q               = rdata_q;
    assign io_output_bus   = out_q;
    // Byte lane within the word is irrelevant: all registers are full words.
    assign unused_addr_lsb = ^address[1:0];

    // Read mux over current register state, so a same-cycle write returns the old value.
    always_comb begin
        rdata = 32'h0;
        case (sel)
            REG_OUT:    rdata = 32'(out_q);
            REG_IN:     rdata = 32'(deb_q);
            REG_EDGE:   rdata = 32'(edge_flags_q);
            REG_TIMER:  rdata = timer_q;
            REG_TCMP:   rdata = tcmp_q;
            REG_STATUS: rdata = {31'h0, status_q};
            default:    rdata = 32'h0;
        endcase
    end

    // Next-state logic: synchroniser, debouncer, edge flags, timer, compare and bus writes.
    always_comb begin
        sync1_d      = io_input_bus;
        sync2_d      = sync1_q;
        deb_d        = deb_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        tcmp_d       = tcmp_q;
        rdata_d      = hit ? rdata : 32'h0;

        for (int i = 0; i < IO_WIDTH; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = 8'h0;
            end else if (cnt_q[i] == DB_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = 8'h0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'h1;
            end
        end

        // Clear requested bits first, then OR in new rising edges so a set wins.
        edge_flags_d = edge_flags_q;
        if (wr && sel == REG_EDGE) begin
            edge_flags_d = edge_flags_q & ~data[IO_WIDTH-1:0];
        end
        edge_flags_d = edge_flags_d | (deb_d & ~deb_q);

        // Compare uses the pre-increment value; a match overrides a coincident clear.
        status_d = status_q;
        if (wr && sel == REG_STATUS && data[0]) begin
            status_d = 1'b0;
        end
        if (timer_q == tcmp_q) begin
            status_d = 1'b1;
        end

        // A timer write replaces that cycle's increment.
        timer_d = timer_q + 32'h1;
        if (wr && sel == REG_TIMER) begin
            timer_d = data;
        end

        if (wr && sel == REG_OUT) begin
            out_d = data[IO_WIDTH-1:0];
        end
        if (wr && sel == REG_TCMP) begin
            tcmp_d = data;
        end
    end

    // State registers; synchronous reset discards any write in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            edge_flags_q <= '0;
            timer_q      <= 32'h0;
            tcmp_q       <= 32'hFFFF_FFFF;
            status_q     <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            edge_flags_q <= edge_flags_d;
            timer_q      <= timer_d;
            tcmp_q       <= tcmp_d;
            status_q     <= status_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_io_peripheral.sv
// Directed bench for io_peripheral: register-map table plus debounce, edge, timer and reset sequences.
// Latency: each tick drives the bus, waits one rising edge, samples 1 time unit later.
// Backpressure: not applicable; the bus is always accepted.
module tb_io_peripheral;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data;
    logic        wren;
    logic        hit;
    logic [31:0] q;
    logic [10:0] io_input_bus;
    logic [10:0] io_output_bus;

    int tests  = 0;
    int failed = 0;

    io_peripheral #(
        .IO_BASE     (32'h0000_0400),
        .IO_WIDTH    (11),
        .DEBOUNCE_LEN(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .data         (data),
        .wren         (wren),
        .hit          (hit),
        .q            (q),
        .io_input_bus (io_input_bus),
        .io_output_bus(io_output_bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        we;
        logic        exp_hit;
        logic [31:0] exp_q;
        logic [10:0] exp_out;
    } vec_t;

    vec_t vecs[16];

    task automatic tick(input logic [31:0] a, input logic [31:0] d, input logic we);
        address = a;
        data    = d;
        wren    = we;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    logic glitch_seen;

    initial begin
        // addr, wdat, we, exp_hit, exp_q (pre-edge read of addr), exp_out after edge
        vecs[0]  = '{32'h0000_0400, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 11'h000};
        vecs[1]  = '{32'h0000_0400, 32'h0000_07FF, 1'b1, 1'b1, 32'h0000_0000, 11'h7FF};
        vecs[2]  = '{32'h0000_0400, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_07FF, 11'h7FF};
        vecs[3]  = '{32'h0000_0440, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 11'h7FF};
        vecs[4]  = '{32'h0000_0440, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 11'h7FF};
        vecs[5]  = '{32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_07FF, 11'h7FF};
        vecs[6]  = '{32'h0000_0403, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_07FF, 11'h7FF};
        vecs[7]  = '{32'h0000_0404, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 11'h7FF};
        vecs[8]  = '{32'h0000_0408, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 11'h7FF};
        vecs[9]  = '{32'h0000_0410, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 11'h7FF};
        vecs[10] = '{32'h0000_0414, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 11'h7FF};
        vecs[11] = '{32'h0000_0400, 32'h0000_0155, 1'b1, 1'b1, 32'h0000_07FF, 11'h155};
        vecs[12] = '{32'h0000_04FC, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 11'h155};
        vecs[13] = '{32'h0000_0000, 32'h0000_02AA, 1'b1, 1'b0, 32'h0000_0000, 11'h155};
        vecs[14] = '{32'h0000_0400, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0155, 11'h155};
        vecs[15] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 11'h155};

        reset        = 1'b1;
        io_input_bus = 11'h000;
        tick(32'h0000_0400, 32'h0, 1'b0);
        tick(32'h0000_0400, 32'h0, 1'b0);
        chk("reset_q", q, 32'h0);
        chk("reset_out", 32'(io_output_bus), 32'h0);
        reset = 1'b0;

        // Register map and decode
        for (int i = 0; i < 16; i++) begin
            tick(vecs[i].addr, vecs[i].wdat, vecs[i].we);
            chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
            chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            chk($sformatf("vec%0d_out", i), 32'(io_output_bus), 32'(vecs[i].exp_out));
        end

        // Three-cycle glitch on bit3 must never reach IN
        glitch_seen  = 1'b0;
        io_input_bus = 11'h008;
        for (int k = 0; k < 3; k++) begin
            tick(32'h0000_0404, 32'h0, 1'b0);
            if (q != 32'h0) glitch_seen = 1'b1;
        end
        io_input_bus = 11'h000;
        for (int k = 0; k < 8; k++) begin
            tick(32'h0000_0404, 32'h0, 1'b0);
            if (q != 32'h0) glitch_seen = 1'b1;
        end
        chk("glitch_in", 32'(glitch_seen), 32'h0);
        tick(32'h0000_0408, 32'h0, 1'b0);
        chk("glitch_edge", q, 32'h0);

        // Held input: IN[3] becomes 1 after the 6th edge, visible on q the tick after
        io_input_bus = 11'h008;
        for (int k = 1; k <= 10; k++) begin
            tick(32'h0000_0404, 32'h0, 1'b0);
            if (k == 6) chk("in_lat_before", q, 32'h0);
            if (k == 7) chk("in_lat_after", q, 32'h8);
        end
        tick(32'h0000_0408, 32'h0, 1'b0);
        chk("edge_bit3", q, 32'h8);

        // Bit5 rises on the same edge that W1C clears bit3
        io_input_bus = 11'h028;
        for (int k = 1; k <= 5; k++) tick(32'h0000_0404, 32'h0, 1'b0);
        tick(32'h0000_0408, 32'h8, 1'b1);
        chk("edge_w1c_prewrite", q, 32'h8);
        tick(32'h0000_0408, 32'h0, 1'b0);
        chk("edge_set_wins", q, 32'h20);
        tick(32'h0000_0404, 32'h0, 1'b0);
        chk("in_bits", q, 32'h28);
        tick(32'h0000_0408, 32'h20, 1'b1);
        chk("edge_w1c2_prewrite", q, 32'h20);
        tick(32'h0000_0408, 32'h0, 1'b0);
        chk("edge_cleared", q, 32'h0);

        // Timer wrap and compare flag
        tick(32'h0000_0410, 32'h0, 1'b1);
        tick(32'h0000_0414, 32'h0, 1'b0);
        chk("status_idle", q, 32'h0);
        tick(32'h0000_040C, 32'hFFFF_FFFE, 1'b1);
        tick(32'h0000_040C, 32'h0, 1'b0);
        chk("timer_load", q, 32'hFFFF_FFFE);
        tick(32'h0000_040C, 32'h0, 1'b0);
        chk("timer_max", q, 32'hFFFF_FFFF);
        tick(32'h0000_040C, 32'h0, 1'b0);
        chk("timer_wrap", q, 32'h0);
        tick(32'h0000_0414, 32'h0, 1'b0);
        chk("status_set", q, 32'h1);
        tick(32'h0000_0414, 32'h1, 1'b1);
        chk("status_prewrite", q, 32'h1);
        tick(32'h0000_0414, 32'h0, 1'b0);
        chk("status_cleared", q, 32'h0);

        // Reset mid-operation with a coincident write
        tick(32'h0000_0400, 32'h2AA, 1'b1);
        chk("out_2aa", 32'(io_output_bus), 32'h2AA);
        reset = 1'b1;
        tick(32'h0000_0400, 32'h155, 1'b1);
        reset = 1'b0;
        chk("rst_out", 32'(io_output_bus), 32'h0);
        chk("rst_q", q, 32'h0);
        tick(32'h0000_040C, 32'h0, 1'b0);
        chk("rst_timer", q, 32'h0);
        tick(32'h0000_0410, 32'h0, 1'b0);
        chk("rst_tcmp", q, 32'hFFFF_FFFF);
        tick(32'h0000_0400, 32'h0, 1'b0);
        chk("rst_out_reg", q, 32'h0);
        tick(32'h0000_0404, 32'h0, 1'b0);
        chk("rst_in", q, 32'h0);
        tick(32'h0000_0408, 32'h0, 1'b0);
        chk("rst_edge", q, 32'h0);
        tick(32'h0000_0414, 32'h0, 1'b0);
        chk("rst_status", q, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
